// File: rtl/instr_encoder.sv
// instr_encoder: program loader that turns a stream of RISC-V instruction
// descriptors into RV32I machine words and writes them into instruction
// memory starting at word address 0. Each accepted descriptor produces one
// write cycle, so the loader moves one word every two clock cycles.

module instr_encoder #(
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [2:0]            in_fmt,
    input  logic [6:0]            in_op,
    input  logic [4:0]            in_rd,
    input  logic [4:0]            in_rs1,
    input  logic [4:0]            in_rs2,
    input  logic [2:0]            in_funct3,
    input  logic [6:0]            in_funct7,
    input  logic [31:0]           in_imm,
    input  logic                  in_last,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [31:0]           mem_wdata,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic [ADDR_WIDTH:0]   count
);

    // Descriptor format codes
    localparam logic [2:0] FMT_R = 3'd0;
    localparam logic [2:0] FMT_I = 3'd1;
    localparam logic [2:0] FMT_S = 3'd2;
    localparam logic [2:0] FMT_B = 3'd3;
    localparam logic [2:0] FMT_U = 3'd4;
    localparam logic [2:0] FMT_J = 3'd5;

    // Highest word address; writing it without a final descriptor is an overflow
    localparam logic [ADDR_WIDTH-1:0] ADDR_MAX = {ADDR_WIDTH{1'b1}};
    localparam logic [ADDR_WIDTH-1:0] ADDR_ZERO = {ADDR_WIDTH{1'b0}};
    localparam logic [ADDR_WIDTH:0]   CNT_ZERO = {(ADDR_WIDTH+1){1'b0}};

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RUN   = 3'd1,
        ST_WRITE = 3'd2,
        ST_DONE  = 3'd3,
        ST_ERR   = 3'd4
    } state_t;

    // Pack descriptor fields into a 32-bit word following the RV32I base formats
    function automatic logic [31:0] encode_word(
        input logic [2:0]  fmt,
        input logic [6:0]  op,
        input logic [4:0]  rd,
        input logic [4:0]  rs1,
        input logic [4:0]  rs2,
        input logic [2:0]  f3,
        input logic [6:0]  f7,
        input logic [31:0] imm
    );
        logic [31:0] w;
        w = 32'h0000_0000;
        case (fmt)
            FMT_R:   w = {f7, rs2, rs1, f3, rd, op};
            FMT_I:   w = {imm[11:0], rs1, f3, rd, op};
            FMT_S:   w = {imm[11:5], rs2, rs1, f3, imm[4:0], op};
            FMT_B:   w = {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], op};
            FMT_U:   w = {imm[31:12], rd, op};
            FMT_J:   w = {imm[20], imm[10:1], imm[11], imm[19:12], rd, op};
            default: w = 32'h0000_0000;
        endcase
        return w;
    endfunction

    // A descriptor is legal when its format exists, the opcode is a 32-bit
    // encoding, and the immediate fits the field the format gives it
    function automatic logic desc_legal(
        input logic [2:0]  fmt,
        input logic [6:0]  op,
        input logic [31:0] imm
    );
        logic fmt_ok;
        fmt_ok = 1'b0;
        case (fmt)
            FMT_R:   fmt_ok = 1'b1;
            // 12-bit signed: bits 31..11 must all be copies of the sign
            FMT_I:   fmt_ok = (imm[31:11] == {21{imm[11]}});
            FMT_S:   fmt_ok = (imm[31:11] == {21{imm[11]}});
            // 13-bit signed, halfword aligned
            FMT_B:   fmt_ok = (imm[31:12] == {20{imm[12]}}) && (imm[0] == 1'b0);
            // Upper immediate carries no low bits
            FMT_U:   fmt_ok = (imm[11:0] == 12'h000);
            // 21-bit signed, halfword aligned
            FMT_J:   fmt_ok = (imm[31:20] == {12{imm[20]}}) && (imm[0] == 1'b0);
            default: fmt_ok = 1'b0;
        endcase
        return fmt_ok && (op[1:0] == 2'b11);
    endfunction

    state_t                  state_r;
    state_t                  next_state_s;
    logic [ADDR_WIDTH-1:0]   addr_r;
    logic [ADDR_WIDTH:0]     count_r;
    logic [ADDR_WIDTH-1:0]   mem_addr_r;
    logic [31:0]             mem_wdata_r;
    logic                    last_r;
    logic                    in_ready_r;
    logic                    busy_r;
    logic                    mem_we_r;
    logic                    done_r;
    logic                    err_r;
    logic                    hs_s;
    logic                    legal_s;
    logic                    start_ok_s;
    logic [31:0]             enc_word_s;

    assign in_ready  = in_ready_r;
    assign busy      = busy_r;
    assign mem_we    = mem_we_r;
    assign done      = done_r;
    assign err       = err_r;
    assign count     = count_r;
    assign mem_addr  = mem_addr_r;
    assign mem_wdata = mem_wdata_r;

    // Handshake, legality and encoding of the presented descriptor
    always_comb begin
        hs_s       = (state_r == ST_RUN) && in_valid;
        start_ok_s = start && ((state_r == ST_IDLE) || (state_r == ST_DONE) ||
                               (state_r == ST_ERR));
        legal_s    = desc_legal(in_fmt, in_op, in_imm);
        enc_word_s = encode_word(in_fmt, in_op, in_rd, in_rs1, in_rs2,
                                 in_funct3, in_funct7, in_imm);
    end

    // Next-state selection for the load sequencer
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_IDLE, ST_DONE, ST_ERR: begin
                if (start) begin
                    next_state_s = ST_RUN;
                end else begin
                    next_state_s = state_r;
                end
            end
            ST_RUN: begin
                if (hs_s) begin
                    if (legal_s) begin
                        next_state_s = ST_WRITE;
                    end else begin
                        next_state_s = ST_ERR;
                    end
                end else begin
                    next_state_s = ST_RUN;
                end
            end
            ST_WRITE: begin
                if (last_r) begin
                    next_state_s = ST_DONE;
                end else if (addr_r == ADDR_MAX) begin
                    next_state_s = ST_ERR;
                end else begin
                    next_state_s = ST_RUN;
                end
            end
            default: next_state_s = ST_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Status and strobe outputs, registered from the upcoming state so they
    // line up exactly with the state they describe
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            in_ready_r <= 1'b0;
            busy_r     <= 1'b0;
            mem_we_r   <= 1'b0;
            done_r     <= 1'b0;
            err_r      <= 1'b0;
        end else begin
            in_ready_r <= (next_state_s == ST_RUN);
            busy_r     <= (next_state_s == ST_RUN) || (next_state_s == ST_WRITE);
            mem_we_r   <= (next_state_s == ST_WRITE);
            done_r     <= (next_state_s == ST_DONE);
            err_r      <= (next_state_s == ST_ERR);
        end
    end

    // Write address and word counter: cleared by an honoured start,
    // advanced once per write cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_r  <= ADDR_ZERO;
            count_r <= CNT_ZERO;
        end else if (start_ok_s) begin
            addr_r  <= ADDR_ZERO;
            count_r <= CNT_ZERO;
        end else if (state_r == ST_WRITE) begin
            addr_r  <= addr_r + ADDR_WIDTH'(1'b1);
            count_r <= count_r + (ADDR_WIDTH+1)'(1'b1);
        end else begin
            addr_r  <= addr_r;
            count_r <= count_r;
        end
    end

    // Capture the encoded word, its address and the last flag on a legal
    // handshake; the memory port holds these values between writes
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_addr_r  <= ADDR_ZERO;
            mem_wdata_r <= 32'h0000_0000;
            last_r      <= 1'b0;
        end else if (hs_s && legal_s) begin
            mem_addr_r  <= addr_r;
            mem_wdata_r <= enc_word_s;
            last_r      <= in_last;
        end else begin
            mem_addr_r  <= mem_addr_r;
            mem_wdata_r <= mem_wdata_r;
            last_r      <= last_r;
        end
    end

endmodule

// File: doc/instr_encoder.md
Name: instr_encoder

Overview:
- Program-loader block: accepts a stream of RISC-V instruction descriptors, encodes each into a 32-bit R/I/S/B/U/J machine word, and writes it sequentially into instruction memory.
- It produces the opcode/format encodings that the main decoder consumes.
- Used by the bench and by the boot path to fill instruction memory from address 0 before the CPU is released.

Parameters:
ADDR_WIDTH, 8, word-address width of the instruction-memory write port; capacity is 2**ADDR_WIDTH words.

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
start  input  1  one-cycle pulse: begin a load at address 0; honoured only in IDLE, DONE or ERR
in_valid  input  1  descriptor valid
in_ready  output  1  descriptor accepted when in_valid&&in_ready at a rising edge
in_fmt  input  3  0=R 1=I 2=S 3=B 4=U 5=J; 6,7 illegal
in_op  input  7  opcode field, e.g. 0010011, 0000011, 0110011, 0100011, 1100011, 0110111, 1101111
in_rd  input  5  destination register
in_rs1  input  5  source register 1
in_rs2  input  5  source register 2
in_funct3  input  3  funct3 field
in_funct7  input  7  funct7 field (R only)
in_imm  input  32  signed byte-offset/immediate value, full width
in_last  input  1  final descriptor of the program
mem_we  output  1  instruction-memory write enable
mem_addr  output  ADDR_WIDTH  word address
mem_wdata  output  32  encoded word
busy  output  1  high in RUN and WRITE
done  output  1  load completed; held until next start
err  output  1  load aborted; held until next start
count  output  ADDR_WIDTH+1  number of words written this load

Behaviour:
- Reset (async, any state, including mid-WRITE):
  - state=IDLE.
  - mem_we=0, mem_addr=0, mem_wdata=0.
  - in_ready=0, busy=0, done=0, err=0, count=0.
- FSM states: IDLE, RUN, WRITE, DONE, ERR.
- IDLE/DONE/ERR on start:
  - Clear done, err, count and the address to 0.
  - Go to RUN.
  - Otherwise hold state.
- start while in RUN or WRITE: ignored.
- RUN:
  - in_ready=1.
  - On handshake, encode combinationally and register word and in_last.
  - Legal descriptor -> WRITE.
  - Illegal descriptor -> ERR, no write.
- WRITE:
  - in_ready=0, mem_we=1 for exactly one cycle.
  - mem_addr = current address, mem_wdata = registered word.
  - At the edge: count+1, address+1.
  - If the registered last is set -> DONE.
  - Else if the address just written was 2**ADDR_WIDTH-1 -> ERR (overflow, no wrap).
  - Else -> RUN.
- Timing: latency is handshake at edge N -> mem_we high during cycle N+1. Throughput is one word per 2 cycles.
- Encoding, all fields placed per the RV32I base formats:
  - R: funct7|rs2|rs1|funct3|rd|op.
  - I: imm[11:0]|rs1|funct3|rd|op.
  - S: imm[11:5]|rs2|rs1|funct3|imm[4:0]|op.
  - B: imm[12]|imm[10:5]|rs2|rs1|funct3|imm[4:1]|imm[11]|op.
  - U: imm[31:12]|rd|op.
  - J: imm[20]|imm[10:1]|imm[11]|imm[19:12]|rd|op.
- Illegal descriptor (any one sends the FSM to ERR):
  - in_fmt of 6 or 7.
  - in_op[1:0] != 2'b11.
  - I/S immediate outside -2048..2047.
  - B immediate outside -4096..4094, or imm[0]=1.
  - J immediate outside -1048576..1048574, or imm[0]=1.
  - U with imm[11:0] != 0.
- Unused fields for a given format are ignored (e.g. rd for S/B, funct7 for I).
- done and err are mutually exclusive. Neither is asserted while busy.
- mem_wdata and mem_addr hold their last values when mem_we=0.

Test Plan:
- addi x1,x0,5 (fmt 1, op 0010011, rd 1, rs1 0, f3 0, imm 5, last 1) after start -> one mem_we pulse the cycle after handshake, addr 0, wdata 0x00500093; then done=1, count=1.
- add x3,x1,x2 (fmt 0, op 0110011, f7 0) then sw x2,8(x1) (fmt 2, op 0100011, f3 010, imm 8, last 1) -> addr 0 gets 0x002081B3, addr 1 gets 0x0020A423; in_ready low during each WRITE; count=2, done=1.
- bne x1,x0,-4 (fmt 3, op 1100011, f3 001, imm -4) -> wdata 0xFE009EE3. The same descriptor with imm -3 -> err=1, no mem_we, in_ready=0 until the next start.
- I-type with imm 2048, and separately fmt 6 -> err=1, count unchanged, no write; a new start clears err and the next load starts at addr 0.
- ADDR_WIDTH=2, five descriptors with last=0 -> addresses 0..3 written, then err=1 after the addr-3 write; the fifth descriptor is never accepted; count=4.
- rst asserted during WRITE -> mem_we drops immediately (async), all outputs return to reset values; start pulsed while busy has no effect.
